contador_botones: RTL and testbench

Debounced up/down event counter that produces the 10-bit binary value consumed by the four-digit BCD 7-segment display decoder. It synchronizes and debounces two raw active-low pushbuttons (board KEY inputs). It turns each clean press into a single count step and exposes the count plus status flags. It sits directly upstream of the decoder; `count_out` connects straight to the decoder's binary input.

---
 rtl/contador_botones.sv | 108 ++++++++++
 tb/tb_contador_botones.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/contador_botones.sv
// Debounced up/down event counter feeding the 4-digit BCD display decoder.
// Define CONTADOR_SATURATE_EN to saturate at 0 / MAX_COUNT instead of wrapping.
module contador_botones #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int MAX_COUNT       = 999
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up_n,
  input  logic       btn_down_n,
  input  logic       clr,
  output logic [9:0] count_out,
  output logic       at_max,
  output logic       at_zero,
  output logic       wrap_pulse
);

  localparam logic [19:0] DB_LAST = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [9:0]  MAX_VAL = 10'(MAX_COUNT);

  logic [1:0] w_btn_n;
  logic [1:0] w_press;
  logic [9:0] r_count;
  logic       r_wrap;

  assign w_btn_n = {btn_down_n, btn_up_n};

  // Index 0 = up button, index 1 = down button; both paths are identical.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic        r_sync1;
      logic        r_sync2;
      logic        r_deb;
      logic        r_deb_d;
      logic        r_press;
      logic [19:0] r_cnt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sync1 <= 1'b1;
          r_sync2 <= 1'b1;
          r_deb   <= 1'b1;
          r_deb_d <= 1'b1;
          r_press <= 1'b0;
          r_cnt   <= '0;
        end else begin
          r_sync1 <= w_btn_n[gi];
          r_sync2 <= r_sync1;
          if (r_sync2 == r_deb) begin
            r_cnt <= '0;
          end else if (r_cnt == DB_LAST) begin
            r_deb <= r_sync2;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 20'd1;
          end
          r_deb_d <= r_deb;
          // Pulse only on the released->pressed edge of the clean level.
          r_press <= r_deb_d & ~r_deb;
        end
      end

      assign w_press[gi] = r_press;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (clr) begin
        r_count <= '0;
      end else if (w_press[0] && w_press[1]) begin
        r_count <= r_count;
      end else if (w_press[0]) begin
        if (r_count == MAX_VAL) begin
`ifdef CONTADOR_SATURATE_EN
          r_count <= r_count;
`else
          r_count <= '0;
          r_wrap  <= 1'b1;
`endif
        end else begin
          r_count <= r_count + 10'd1;
        end
      end else if (w_press[1]) begin
        if (r_count == 10'd0) begin
`ifdef CONTADOR_SATURATE_EN
          r_count <= r_count;
`else
          r_count <= MAX_VAL;
          r_wrap  <= 1'b1;
`endif
        end else begin
          r_count <= r_count - 10'd1;
        end
      end
    end
  end

  assign count_out  = r_count;
  assign wrap_pulse = r_wrap;
  assign at_max     = (r_count == MAX_VAL);
  assign at_zero    = (r_count == 10'd0);

endmodule

// File: tb/tb_contador_botones.sv
// Randomized bench for contador_botones against a sample-history reference model.
module tb_contador_botones;

  localparam int D   = 4;
  localparam int MAX = 9;

  logic       clk;
  logic       rst_n;
  logic       btn_up_n;
  logic       btn_down_n;
  logic       clr;
  logic [9:0] count_out;
  logic       at_max;
  logic       at_zero;
  logic       wrap_pulse;

  int n_checks = 0;
  int n_errors = 0;

  contador_botones #(.DEBOUNCE_CYCLES(D), .MAX_COUNT(MAX)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_up_n   (btn_up_n),
    .btn_down_n (btn_down_n),
    .clr        (clr),
    .count_out  (count_out),
    .at_max     (at_max),
    .at_zero    (at_zero),
    .wrap_pulse (wrap_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: raw samples per edge; the clean level flips once the
  // D samples seen through the 2-flop delay all disagree with it. A press
  // taken at edge e moves the count at edge e+2.
  bit hu [0:D+1];
  bit hd [0:D+1];
  bit m_deb_u, m_deb_d;
  bit evu [0:2];
  bit evd [0:2];
  int m_count;
  bit m_wrap;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    bit fu, fd, pu, pd;
    if (!rst_n) begin
      for (int k = 0; k <= D + 1; k++) begin
        hu[k] = 1'b1;
        hd[k] = 1'b1;
      end
      m_deb_u = 1'b1;
      m_deb_d = 1'b1;
      for (int k = 0; k < 3; k++) begin
        evu[k] = 1'b0;
        evd[k] = 1'b0;
      end
      m_count = 0;
      m_wrap  = 1'b0;
      return;
    end
    for (int k = D + 1; k > 0; k--) begin
      hu[k] = hu[k-1];
      hd[k] = hd[k-1];
    end
    hu[0] = btn_up_n;
    hd[0] = btn_down_n;
    fu = 1'b1;
    fd = 1'b1;
    for (int k = 2; k <= D + 1; k++) begin
      if (hu[k] == m_deb_u) fu = 1'b0;
      if (hd[k] == m_deb_d) fd = 1'b0;
    end
    pu = fu && m_deb_u;
    pd = fd && m_deb_d;
    if (fu) m_deb_u = ~m_deb_u;
    if (fd) m_deb_d = ~m_deb_d;
    evu[2] = evu[1]; evu[1] = evu[0]; evu[0] = pu;
    evd[2] = evd[1]; evd[1] = evd[0]; evd[0] = pd;
    m_wrap = 1'b0;
    if (clr) begin
      m_count = 0;
    end else if (evu[2] && evd[2]) begin
      m_count = m_count;
    end else if (evu[2]) begin
      if (m_count == MAX) begin
`ifndef CONTADOR_SATURATE_EN
        m_count = 0;
        m_wrap  = 1'b1;
`endif
      end else begin
        m_count = m_count + 1;
      end
    end else if (evd[2]) begin
      if (m_count == 0) begin
`ifndef CONTADOR_SATURATE_EN
        m_count = MAX;
        m_wrap  = 1'b1;
`endif
      end else begin
        m_count = m_count - 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("count", int'(count_out), m_count);
    chk("wrap", int'(wrap_pulse), int'(m_wrap));
    chk("at_max", int'(at_max), int'(m_count == MAX));
    chk("at_zero", int'(at_zero), int'(m_count == 0));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input bit up, input bit down);
    btn_up_n   = ~up;
    btn_down_n = ~down;
    ticks(10);
    btn_up_n   = 1'b1;
    btn_down_n = 1'b1;
    ticks(10);
  endtask

  int ru, rd;

  initial begin
    rst_n      = 1'b0;
    btn_up_n   = 1'b1;
    btn_down_n = 1'b1;
    clr        = 1'b0;
    ticks(3);
    chk("reset_count", int'(count_out), 0);
    chk("reset_at_zero", int'(at_zero), 1);
    chk("reset_at_max", int'(at_max), 0);
    chk("reset_wrap", int'(wrap_pulse), 0);
    rst_n = 1'b1;
    ticks(2);

    // Held press: exactly one step, 7 edges after first sample.
    btn_up_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_count", int'(count_out), (i >= 7) ? 1 : 0);
    end
    btn_up_n = 1'b1;
    ticks(12);

    // Bounce every 2 cycles, then a stable low.
    for (int i = 0; i < 12; i++) begin
      btn_up_n = ((i / 2) % 2 == 1);
      tick();
      chk("bounce_count", int'(count_out), 1);
    end
    btn_up_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bounce_settle", int'(count_out), (i >= 7) ? 2 : 1);
    end
    btn_up_n = 1'b1;
    ticks(12);

    clr = 1'b1;
    tick();
    chk("clr_count", int'(count_out), 0);
    clr = 1'b0;

    for (int i = 0; i < 9; i++) press(1'b1, 1'b0);
    chk("nine_count", int'(count_out), 9);
    chk("nine_at_max", int'(at_max), 1);

    btn_up_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
`ifdef CONTADOR_SATURATE_EN
      if (i == 7) chk("up_at_max", int'(count_out), 9);
      if (i == 7) chk("up_at_max_wrap", int'(wrap_pulse), 0);
`else
      if (i == 7) chk("up_wrap_count", int'(count_out), 0);
      if (i == 7) chk("up_wrap_pulse", int'(wrap_pulse), 1);
      if (i == 8) chk("up_wrap_one_cycle", int'(wrap_pulse), 0);
`endif
    end
    btn_up_n = 1'b1;
    ticks(10);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    btn_down_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
`ifdef CONTADOR_SATURATE_EN
      if (i == 7) chk("down_at_zero", int'(count_out), 0);
      if (i == 7) chk("down_at_zero_wrap", int'(wrap_pulse), 0);
`else
      if (i == 7) chk("down_wrap_count", int'(count_out), 9);
      if (i == 7) chk("down_wrap_pulse", int'(wrap_pulse), 1);
`endif
    end
    btn_down_n = 1'b1;
    ticks(10);

    // Simultaneous up/down at 5, then clr colliding with an up pulse.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 5; i++) press(1'b1, 1'b0);
    chk("five_count", int'(count_out), 5);
    press(1'b1, 1'b1);
    chk("both_count", int'(count_out), 5);
    btn_up_n = 1'b0;
    ticks(7);
    clr = 1'b1;
    tick();
    chk("clr_up_count", int'(count_out), 0);
    chk("clr_up_wrap", int'(wrap_pulse), 0);
    clr = 1'b0;
    btn_up_n = 1'b1;
    ticks(10);

    // Async reset mid-debounce with the button still held afterwards.
    for (int i = 0; i < 3; i++) press(1'b1, 1'b0);
    chk("three_count", int'(count_out), 3);
    btn_up_n = 1'b0;
    ticks(3);
    rst_n = 1'b0;
    #1;
    chk("async_reset_count", int'(count_out), 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("post_reset_count", int'(count_out), (i >= 7) ? 1 : 0);
    end
    btn_up_n = 1'b1;
    ticks(10);

    // Random bouncy buttons with occasional clears.
    ru = 0;
    rd = 0;
    for (int n = 0; n < 3000; n++) begin
      if (ru == 0) begin
        btn_up_n = 1'($urandom_range(0, 1));
        ru = int'($urandom_range(1, 12));
      end
      if (rd == 0) begin
        btn_down_n = 1'($urandom_range(0, 1));
        rd = int'($urandom_range(1, 12));
      end
      ru--;
      rd--;
      clr = ($urandom_range(0, 63) == 0);
      tick();
    end
    clr = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
